approx_mult_pipe: RTL and testbench

Pipelined, parametrised unsigned W×W multiplier with per-transaction mode selection: exact, approximate (carry-free OR compression of the low product columns), or approximate with partial error recovery. It is the clocked successor to our fixed 16-bit combinational approximate multiplier with error recovery. It uses a valid/ready stream interface with full backpressure and a saturating mismatch counter for characterisation runs. It sits between operand FIFOs and the accumulator datapath.

---
 rtl/approx_mult_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_approx_mult_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_pipe.sv
// Pipelined unsigned WxW multiplier: exact, carry-free approximate, or partially recovered product per beat.
// Latency log2(W)+2; a stalled output freezes every stage, so in_ready drops combinationally while stalled.
module approx_mult_pipe #(
   parameter int W = 16,
   parameter int K = 16,
   parameter int R = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      a,
   input  logic [W-1:0]      b,
   input  logic [1:0]        mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*W-1:0]    res,
   output logic              err_nz,
   output logic [15:0]       err_cnt,
   input  logic              cnt_clr
);

   localparam int LG = $clog2(W);
   localparam int PW = 2 * W;
   localparam logic [PW-1:0] LOW_MASK = (K >= PW) ? {PW{1'b1}} : ((PW'(1) << K) - PW'(1));

   logic stall;
   logic adv;
   logic out_vld_q;

   assign stall    = out_vld_q & ~out_ready;
   assign adv      = ~stall;
   assign in_ready = adv;

   // Stage 0: operand capture
   logic [W-1:0] a_d, a_q, b_d, b_q;
   logic [1:0]   mode_d, mode_q;
   logic         vld0_d, vld0_q;

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      mode_d = mode_q;
      vld0_d = vld0_q;
      if (adv) begin
         a_d    = a;
         b_d    = b;
         mode_d = mode;
         vld0_d = in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         mode_q <= '0;
         vld0_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         mode_q <= mode_d;
         vld0_q <= vld0_d;
      end
   end

   // All tree levels share flat arrays; level s with N rows starts at row 2W-2N.
   // hi: exact sum of columns >= K, lx: exact sum of columns < K, lo: OR of columns < K.
   logic [PW-1:0] row_hi [2*W-1];
   logic [PW-1:0] row_lx [2*W-1];
   logic [PW-1:0] row_lo [2*W-1];
   logic          row_vld [LG+1];
   logic [1:0]    row_mode [LG+1];

   genvar gi, gs, gj;
   for (gi = 0; gi < W; gi++) begin : g_pp
      assign row_hi[gi] = (PW'(a_q & {W{b_q[gi]}}) << gi) & ~LOW_MASK;
      assign row_lx[gi] = (PW'(a_q & {W{b_q[gi]}}) << gi) & LOW_MASK;
      assign row_lo[gi] = (PW'(a_q & {W{b_q[gi]}}) << gi) & LOW_MASK;
   end
   assign row_vld[0]  = vld0_q;
   assign row_mode[0] = mode_q;

   for (gs = 1; gs <= LG; gs++) begin : g_lvl
      localparam int N  = W >> gs;
      localparam int OI = 2 * W - 4 * N;
      localparam int OO = 2 * W - 2 * N;

      logic [PW-1:0] hi_d [N];
      logic [PW-1:0] hi_q [N];
      logic [PW-1:0] lx_d [N];
      logic [PW-1:0] lx_q [N];
      logic [PW-1:0] lo_d [N];
      logic [PW-1:0] lo_q [N];
      logic          vld_d, vld_q;
      logic [1:0]    mode_d, mode_q;

      always_comb begin
         hi_d   = hi_q;
         lx_d   = lx_q;
         lo_d   = lo_q;
         vld_d  = vld_q;
         mode_d = mode_q;
         if (adv) begin
            for (int r = 0; r < N; r++) begin
               hi_d[r] = row_hi[OI + 2*r] + row_hi[OI + 2*r + 1];
               lx_d[r] = row_lx[OI + 2*r] + row_lx[OI + 2*r + 1];
               lo_d[r] = row_lo[OI + 2*r] | row_lo[OI + 2*r + 1];
            end
            vld_d  = row_vld[gs-1];
            mode_d = row_mode[gs-1];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int r = 0; r < N; r++) begin
               hi_q[r] <= '0;
               lx_q[r] <= '0;
               lo_q[r] <= '0;
            end
            vld_q  <= 1'b0;
            mode_q <= '0;
         end else begin
            hi_q   <= hi_d;
            lx_q   <= lx_d;
            lo_q   <= lo_d;
            vld_q  <= vld_d;
            mode_q <= mode_d;
         end
      end

      for (gj = 0; gj < N; gj++) begin : g_out
         assign row_hi[OO + gj] = hi_q[gj];
         assign row_lx[OO + gj] = lx_q[gj];
         assign row_lo[OO + gj] = lo_q[gj];
      end
      assign row_vld[gs]  = vld_q;
      assign row_mode[gs] = mode_q;
   end

   // Final stage: P, PA, E, PR and mode select
   localparam int LAST = 2 * W - 2;

   logic [PW-1:0] p_full, pa, e, pr;
   logic [PW-1:0] res_d, res_q;
   logic          err_nz_d, err_nz_q;
   logic          mis_d, mis_q;
   logic          out_vld_d;
   logic [15:0]   err_cnt_d, err_cnt_q;

   always_comb begin
      p_full    = row_hi[LAST] + row_lx[LAST];
      pa        = row_hi[LAST] + row_lo[LAST];
      e         = p_full - pa;
      pr        = pa + ((e >> R) << R);
      res_d     = res_q;
      err_nz_d  = err_nz_q;
      mis_d     = mis_q;
      out_vld_d = out_vld_q;
      if (adv) begin
         out_vld_d = row_vld[LG];
         err_nz_d  = (e != '0);
         case (row_mode[LG])
            2'b01:   res_d = pa;
            2'b10:   res_d = pr;
            default: res_d = p_full;
         endcase
         mis_d = (res_d != p_full);
      end
      // Clear takes priority over a counting delivery in the same cycle.
      err_cnt_d = err_cnt_q;
      if (cnt_clr)
         err_cnt_d = '0;
      else if (out_vld_q && out_ready && mis_q && (err_cnt_q != 16'hFFFF))
         err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_q     <= '0;
         err_nz_q  <= 1'b0;
         mis_q     <= 1'b0;
         out_vld_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         res_q     <= res_d;
         err_nz_q  <= err_nz_d;
         mis_q     <= mis_d;
         out_vld_q <= out_vld_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign out_valid = out_vld_q;
   assign res       = res_q;
   assign err_nz    = err_nz_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe: default build plus W=8 (K=6,R=1) and W=32 (K=20,R=3) builds on shared stimulus.
module tb_approx_mult_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        cnt_clr;
   logic [31:0] a32, b32;
   logic [1:0]  mode;

   logic        ir16, ov16, en16;
   logic [31:0] res16;
   logic [15:0] ec16;
   logic        ir8, ov8, en8;
   logic [15:0] res8;
   logic [15:0] ec8;
   logic        ir32, ov32, en32;
   logic [63:0] res32;
   logic [15:0] ec32;

   int tests = 0;
   int fails = 0;
   int dlv   = 0;

   logic [64:0] sb16[$];
   logic [64:0] sb8[$];
   logic [64:0] sb32[$];
   logic [64:0] got[$];

   approx_mult_pipe #(.W(16), .K(16), .R(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
      .a(a32[15:0]), .b(b32[15:0]), .mode(mode),
      .out_valid(ov16), .out_ready(out_ready), .res(res16), .err_nz(en16),
      .err_cnt(ec16), .cnt_clr(cnt_clr));

   approx_mult_pipe #(.W(8), .K(6), .R(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
      .a(a32[7:0]), .b(b32[7:0]), .mode(mode),
      .out_valid(ov8), .out_ready(out_ready), .res(res8), .err_nz(en8),
      .err_cnt(ec8), .cnt_clr(cnt_clr));

   approx_mult_pipe #(.W(32), .K(20), .R(3)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
      .a(a32), .b(b32), .mode(mode),
      .out_valid(ov32), .out_ready(out_ready), .res(res32), .err_nz(en32),
      .err_cnt(ec32), .cnt_clr(cnt_clr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit-level reference: {err_nz, res}
   function automatic logic [64:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input int w, input int k, input int r,
                                         input logic [1:0] m);
      logic [63:0] p, lo, hi, pa, e, pr, mask, rs;
      mask = (w == 32) ? '1 : ((64'd1 << (2*w)) - 64'd1);
      p  = {32'h0, x} * {32'h0, y};
      lo = '0;
      hi = '0;
      for (int i = 0; i < w; i++)
         for (int j = 0; j < w; j++)
            if (x[i] && y[j]) begin
               if (i + j < k) lo[i+j] = 1'b1;
               else           hi = hi + (64'd1 << (i + j));
            end
      hi = hi & mask;
      pa = (lo + hi) & mask;
      e  = p - pa;
      pr = (pa + ((e >> r) << r)) & mask;
      rs = (m == 2'b01) ? pa : (m == 2'b10) ? pr : p;
      return {(e != 64'd0), rs};
   endfunction

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
      a32 = x; b32 = y; mode = m; in_valid = 1'b1;
      step();
   endtask

   // Scoreboard: push on accept, pop and compare on delivery
   always @(negedge clk) begin
      logic [64:0] exp;
      if (rst) begin
         sb16.delete(); sb8.delete(); sb32.delete();
      end else begin
         if (in_valid && ir16) sb16.push_back(model({16'h0, a32[15:0]}, {16'h0, b32[15:0]}, 16, 16, 4, mode));
         if (in_valid && ir8)  sb8.push_back(model({24'h0, a32[7:0]}, {24'h0, b32[7:0]}, 8, 6, 1, mode));
         if (in_valid && ir32) sb32.push_back(model(a32, b32, 32, 20, 3, mode));
         if (ov16 && out_ready) begin
            dlv++;
            got.push_back({en16, 32'h0, res16});
            exp = (sb16.size() > 0) ? sb16.pop_front() : '1;
            chk("sb_w16", {en16, 32'h0, res16}, exp);
         end
         if (ov8 && out_ready) begin
            exp = (sb8.size() > 0) ? sb8.pop_front() : '1;
            chk("sb_w8", {en8, 48'h0, res8}, exp);
         end
         if (ov32 && out_ready) begin
            exp = (sb32.size() > 0) ? sb32.pop_front() : '1;
            chk("sb_w32", {en32, res32}, exp);
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, gaps, dlv0, idx, t, unstable, stalled_ir;
      logic [31:0] held;
      logic acc;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      a32 = '0; b32 = '0; mode = '0;
      repeat (3) step();
      chkn("rst_out_valid", int'(ov16), 0);
      chk("rst_res", 65'(res16), 65'd0);
      chkn("rst_err_nz", int'(en16), 0);
      chkn("rst_err_cnt", int'(ec16), 0);
      rst = 1'b0;
      step();
      chkn("in_ready_after_rst", int'(ir16), 1);

      // 3*3 in modes 00/01/10, plus first-beat latency
      got.delete();
      send(3, 3, 2'b00); n = 1;
      send(3, 3, 2'b01); n++;
      send(3, 3, 2'b10); n++;
      in_valid = 1'b0;
      while (!ov16 && n < 30) begin step(); n++; end
      chkn("latency", n, 6);
      repeat (10) step();
      chk("res_mode00", got[0], {1'b1, 64'd9});
      chk("res_mode01", got[1], {1'b1, 64'd7});
      chk("res_mode10", got[2], {1'b1, 64'd7});
      chkn("err_cnt_3x3", int'(ec16), 2);
      chkn("err_cnt_w8_r1", int'(ec8), 1);
      chkn("err_cnt_w32", int'(ec32), 2);

      // No column overlap: approximation is exact
      got.delete();
      send(32'hFFFF, 32'h1, 2'b01);
      send(32'h8000, 32'h8000, 2'b01);
      in_valid = 1'b0;
      repeat (10) step();
      chk("no_overlap_ffff", got[0], {1'b0, 64'h0000_FFFF});
      chk("no_overlap_8000", got[1], {1'b0, 64'h4000_0000});

      // Back-to-back random stream
      gaps = 0; dlv0 = dlv;
      for (int k = 0; k < 1000; k++) begin
         a32 = $urandom; b32 = $urandom; mode = 2'($urandom_range(0, 3)); in_valid = 1'b1;
         #1;
         if (!ir16) gaps++;
         step();
         if (k >= 5 && !ov16) gaps++;
      end
      in_valid = 1'b0;
      repeat (10) step();
      chkn("no_bubbles", gaps, 0);
      chkn("rand_delivered", dlv - dlv0, 1000);

      // Backpressure: out_ready low for 5 cycles mid-stream
      dlv0 = dlv; idx = 0; t = 0; unstable = 0; stalled_ir = 0; held = '0;
      a32 = $urandom; b32 = $urandom; mode = 2'($urandom_range(0, 3)); in_valid = 1'b1;
      while (idx < 20 && t < 200) begin
         out_ready = !(t >= 10 && t < 15);
         #2;
         if (t == 10) held = res16;
         if (!out_ready) begin
            if (ir16) stalled_ir++;
            if (res16 !== held) unstable++;
         end
         acc = ir16;
         step();
         t++;
         if (acc) begin
            idx++;
            a32 = $urandom; b32 = $urandom; mode = 2'($urandom_range(0, 3));
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (12) step();
      chkn("bp_in_ready_low", stalled_ir, 0);
      chkn("bp_res_stable", unstable, 0);
      chkn("bp_delivered", dlv - dlv0, 20);
      chkn("bp_sb_empty", sb16.size(), 0);

      // Reset with 4 beats in flight
      dlv0 = dlv;
      for (int k = 0; k < 4; k++) send($urandom, $urandom, 2'b01);
      in_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      chkn("flush_out_valid", int'(ov16), 0);
      chkn("flush_err_cnt", int'(ec16), 0);
      repeat (12) step();
      chkn("flush_none_out", dlv - dlv0, 0);

      // Saturation of err_cnt
      a32 = 3; b32 = 3; mode = 2'b01; in_valid = 1'b1;
      repeat (65540) step();
      in_valid = 1'b0;
      repeat (10) step();
      chkn("err_cnt_sat", int'(ec16), 32'hFFFF);

      // Clear wins over a counting delivery
      send(3, 3, 2'b01);
      in_valid = 1'b0;
      n = 0;
      while (!ov16 && n < 20) begin step(); n++; end
      chkn("clr_wait_valid", int'(ov16), 1);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chkn("clr_wins", int'(ec16), 0);
      chkn("clr_delivered", int'(ov16), 0);
      send(3, 3, 2'b01);
      in_valid = 1'b0;
      repeat (10) step();
      chkn("count_after_clr", int'(ec16), 1);
      chkn("sb_all_empty", sb16.size() + sb8.size() + sb32.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
